// File: rtl/knn_result_writer.sv
// KNN result logger: queues inferred types and writes them to SDRAM
// with a fixed gap, then a summary word; tracks a per-type histogram.
`timescale 1ns/1ps
module knn_result_writer #(
  parameter int W = 16,
  parameter int TYPE_W = 3,
  parameter int ADDR_W = 25,
  parameter logic [ADDR_W-1:0] BASE_R_ADDR =
    ADDR_W'(3) << (ADDR_W-2),
  parameter int MAX_RESULTS = 10,
  parameter int DEPTH = 4,
  parameter int GAP = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              inference_done,
  input  logic [TYPE_W-1:0] inferred_type,
  output logic              write,
  output logic [ADDR_W-1:0] writeaddress,
  output logic [W-1:0]      writedata,
  output logic              busy,
  output logic              log_done,
  output logic              overflow,
  output logic [8*(1<<TYPE_W)-1:0] histogram
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int HW = 8 * (1 << TYPE_W);
  localparam logic [ADDR_W-1:0] SUM_ADDR =
    BASE_R_ADDR + ADDR_W'(MAX_RESULTS * W);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_WRITE, S_GAP, S_SUM, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic              edge_q, edge_d;
  logic              low_q, low_d;
  logic [TYPE_W-1:0] mem_q [DEPTH];
  logic [TYPE_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        seq_q, seq_d;
  logic [7:0]        gap_q, gap_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ovf_q, ovf_d;
  logic [HW-1:0]     hist_q, hist_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [W-1:0]      wdata_q, wdata_d;

  logic idle_or_done, arm_go, rise, push, pop, full, accept;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
  assign arm_go = arm && idle_or_done;
  // A level held high across reset must first be seen low.
  assign rise   = inference_done && !edge_q && low_q;
  assign push   = rise && !idle_or_done;
  assign pop    = (state_q == S_WRITE);
  assign full   = (cnt_q == CW'(DEPTH));
  assign accept = push && (!full || pop);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (arm) state_d = S_WAIT;
      S_WAIT:  if (cnt_q != '0) state_d = S_WRITE;
      S_WRITE: state_d = S_GAP;
      S_GAP:
        if (gap_q == 8'(GAP - 1))
          state_d = (seq_q == 8'(MAX_RESULTS)) ? S_SUM : S_WAIT;
      S_SUM:   state_d = S_DONE;
      S_DONE:  if (arm) state_d = S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end

  // Write strobe, address and data, registered one cycle ahead.
  always_comb begin
    write_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (state_q == S_WAIT && state_d == S_WRITE) begin
      write_d = 1'b1;
      waddr_d = addr_q;
      wdata_d = '0;
      wdata_d[15:8] = seq_q;
      wdata_d[TYPE_W-1:0] = mem_q[rd_q];
    end else if (state_q == S_GAP && state_d == S_SUM) begin
      write_d = 1'b1;
      waddr_d = SUM_ADDR;
      wdata_d = '0;
      wdata_d[15] = ovf_d;
      wdata_d[7:0] = seq_q;
    end
  end

  // FIFO, counters, histogram and sticky flags.
  always_comb begin
    edge_d = inference_done;
    low_d  = low_q || !inference_done;
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    seq_d  = seq_q;
    gap_d  = gap_q;
    addr_d = addr_q;
    ovf_d  = ovf_q;
    hist_d = hist_q;
    if (arm_go) begin
      wr_d   = '0;
      rd_d   = '0;
      cnt_d  = '0;
      seq_d  = '0;
      gap_d  = '0;
      addr_d = BASE_R_ADDR;
      ovf_d  = 1'b0;
      hist_d = '0;
    end else begin
      if (accept) begin
        mem_d[wr_q] = inferred_type;
        wr_d = inc(wr_q);
      end
      if (push && full && !pop) ovf_d = 1'b1;
      if (push && hist_q[8*inferred_type +: 8] != 8'hFF)
        hist_d[8*inferred_type +: 8] =
          hist_q[8*inferred_type +: 8] + 8'd1;
      if (pop) begin
        rd_d   = inc(rd_q);
        seq_d  = seq_q + 8'd1;
        addr_d = addr_q + ADDR_W'(W);
      end
      cnt_d = cnt_q + CW'(accept) - CW'(pop);
      if (state_q == S_WRITE) gap_d = '0;
      else if (state_q == S_GAP) gap_d = gap_q + 8'd1;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_q  <= 1'b0;
      low_q   <= 1'b0;
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      seq_q   <= '0;
      gap_q   <= '0;
      addr_q  <= BASE_R_ADDR;
      ovf_q   <= 1'b0;
      hist_q  <= '0;
      write_q <= 1'b0;
      waddr_q <= BASE_R_ADDR;
      wdata_q <= '0;
    end else begin
      edge_q  <= edge_d;
      low_q   <= low_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
      gap_q   <= gap_d;
      addr_q  <= addr_d;
      ovf_q   <= ovf_d;
      hist_q  <= hist_d;
      write_q <= write_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign write        = write_q;
  assign writeaddress = waddr_q;
  assign writedata    = wdata_q;
  assign busy         = !idle_or_done;
  assign log_done     = (state_q == S_DONE);
  assign overflow     = ovf_q;
  assign histogram    = hist_q;

endmodule

// File: tb/tb_knn_result_writer.sv
// Directed bench for knn_result_writer: logging, overflow,
// reset abandon, held level, histogram saturation.
`timescale 1ns/1ps
module tb_knn_result_writer;

  localparam logic [24:0] BASE = 25'h180_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic arm = 1'b0;
  logic idone = 1'b0;
  logic [2:0] itype = '0;
  logic write, busy, log_done, overflow;
  logic [24:0] waddr;
  logic [15:0] wdata;
  logic [63:0] hist;

  logic arm2 = 1'b0;
  logic idone2 = 1'b0;
  logic [2:0] itype2 = '0;
  logic write2, busy2, log_done2, overflow2;
  logic [24:0] waddr2;
  logic [15:0] wdata2;
  logic [63:0] hist2;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [24:0] a;
    logic [15:0] d;
  } wr_t;
  wr_t wq[$];

  knn_result_writer dut (
    .clk(clk), .rst(rst), .arm(arm),
    .inference_done(idone), .inferred_type(itype),
    .write(write), .writeaddress(waddr),
    .writedata(wdata), .busy(busy),
    .log_done(log_done), .overflow(overflow),
    .histogram(hist)
  );

  knn_result_writer #(.MAX_RESULTS(255), .GAP(1)) dut2 (
    .clk(clk), .rst(rst), .arm(arm2),
    .inference_done(idone2), .inferred_type(itype2),
    .write(write2), .writeaddress(waddr2),
    .writedata(wdata2), .busy(busy2),
    .log_done(log_done2), .overflow(overflow2),
    .histogram(hist2)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (write === 1'b1) wq.push_back('{waddr, wdata});

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int idx,
                        input logic [24:0] a, input logic [15:0] d);
    logic [63:0] obs;
    if (idx < wq.size()) obs = {23'b0, wq[idx]};
    else obs = 'x;
    chk(tag, obs, {23'b0, a, d});
  endtask

  task automatic pulse(input logic [2:0] t, input int hi, input int lo);
    itype = t;
    idone = 1'b1;
    step(hi);
    idone = 1'b0;
    step(lo);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step(1);
    arm = 1'b0;
  endtask

  initial begin
    step(2);
    chk("rst_write", 64'(write), 64'd0);
    chk("rst_waddr", 64'(waddr), 64'(BASE));
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_flags", {61'd0, busy, log_done, overflow}, 64'd0);
    chk("rst_hist", hist, 64'd0);
    rst = 1'b1;
    step(2);

    // results before any arm are ignored
    for (int i = 0; i < 3; i++) pulse(3'd1, 1, 3);
    chk("idle_nowr", 64'(wq.size()), 64'd0);
    chk("idle_hist", hist, 64'd0);

    // basic log of ten results
    do_arm();
    chk("arm_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 10; i++) pulse(3'(i % 5 + 1), 1, 19);
    step(30);
    chk("log_cnt", 64'(wq.size()), 64'd11);
    for (int i = 0; i < 10; i++)
      chk_wr("log_wr", i, BASE + 25'(16 * i),
             16'((i << 8) | (i % 5 + 1)));
    chk_wr("log_sum", 10, BASE + 25'd160, 16'h000A);
    chk("log_done", {62'd0, log_done, busy}, 64'd2);
    chk("log_ovf", 64'(overflow), 64'd0);
    chk("log_hist", hist, 64'h0000_0202_0202_0200);

    // results after DONE are ignored
    wq.delete();
    for (int i = 0; i < 3; i++) pulse(3'd4, 1, 3);
    chk("done_nowr", 64'(wq.size()), 64'd0);
    chk("done_hist", hist, 64'h0000_0202_0202_0200);
    chk("done_stay", 64'(log_done), 64'd1);

    // burst of six results overruns the four-deep queue
    do_arm();
    chk("rearm_clr", {hist[62:0], log_done}, 64'd0);
    for (int i = 0; i < 6; i++) pulse(3'(i + 2), 1, 1);
    step(60);
    chk("burst_ovf", 64'(overflow), 64'd1);
    for (int i = 0; i < 5; i++) pulse(3'd1, 1, 19);
    step(30);
    chk("burst_cnt", 64'(wq.size()), 64'd11);
    for (int i = 0; i < 5; i++)
      chk_wr("burst_wr", i, BASE + 25'(16 * i),
             16'((i << 8) | (i + 2)));
    for (int i = 5; i < 10; i++)
      chk_wr("burst_wr1", i, BASE + 25'(16 * i),
             16'((i << 8) | 1));
    chk_wr("burst_sum", 10, BASE + 25'd160, 16'h800A);
    chk("burst_hist", hist, 64'h0101_0101_0101_0500);

    // reset mid-log abandons it
    wq.delete();
    do_arm();
    pulse(3'd1, 1, 19);
    pulse(3'd2, 1, 19);
    pulse(3'd3, 1, 5);
    chk("mid_cnt", 64'(wq.size()), 64'd3);
    chk_wr("mid_wr2", 2, BASE + 25'd32, 16'h0203);
    idone = 1'b1;
    rst = 1'b0;
    #1;
    chk("arst_write", 64'(write), 64'd0);
    chk("arst_waddr", 64'(waddr), 64'(BASE));
    chk("arst_wdata", 64'(wdata), 64'd0);
    chk("arst_flags", {61'd0, busy, log_done, overflow}, 64'd0);
    chk("arst_hist", hist, 64'd0);
    step(3);
    rst = 1'b1;
    // level still high at release: not a new result
    do_arm();
    step(10);
    chk("held_nowr", 64'(wq.size()), 64'd3);
    chk("held_hist", hist, 64'd0);

    // one long high level is one result, log restarts at BASE
    idone = 1'b0;
    step(1);
    pulse(3'd3, 50, 30);
    chk("long_cnt", 64'(wq.size()), 64'd4);
    chk_wr("long_wr", 3, BASE, 16'h0003);
    chk("long_hist", hist, 64'h0000_0000_0100_0000);

    // histogram saturates at 255
    arm2 = 1'b1;
    step(1);
    arm2 = 1'b0;
    chk("sat_arm", hist2, 64'd0);
    for (int i = 0; i < 300; i++) begin
      idone2 = 1'b1;
      step(1);
      idone2 = 1'b0;
      step(1);
    end
    chk("sat_hist", hist2, 64'h0000_0000_0000_00FF);
    chk("sat_ovf", 64'(overflow2), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/knn_result_writer.md
KNN_RESULT_WRITER -- requirements
Module: knn_result_writer

Interface
REQ-001 SHALL have parameter W, default 16, SDRAM data width.
REQ-002 SHALL have parameter TYPE_W, default 3, width of the inferred type.
REQ-003 SHALL have parameter ADDR_W, default 25, SDRAM address width.
REQ-004 SHALL have parameter BASE_R_ADDR, default 3<<(ADDR_W-2), base address of the result log.
REQ-005 SHALL have parameter MAX_RESULTS, default 10, number of results per log; valid range 1..255.
REQ-006 SHALL have parameter DEPTH, default 4, result FIFO depth; power of two.
REQ-007 SHALL have parameter GAP, default 8, idle cycles between SDRAM writes; valid range 1..255.
REQ-008 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-009 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-010 SHALL have port arm, input, 1, one-cycle pulse that starts a new log.
REQ-011 SHALL have port inference_done, input, 1, level from the KNN system; a result is taken on its rising edge.
REQ-012 SHALL have port inferred_type, input, TYPE_W, sampled in the same cycle as the inference_done rising edge.
REQ-013 SHALL have port write, output, 1, one-cycle SDRAM write strobe.
REQ-014 SHALL have port writeaddress, output, ADDR_W, SDRAM write address.
REQ-015 SHALL have port writedata, output, W, SDRAM write data.
REQ-016 SHALL have port busy, output, 1, high in every state except IDLE and DONE.
REQ-017 SHALL have port log_done, output, 1, sticky; high in DONE.
REQ-018 SHALL have port overflow, output, 1, sticky; set when a result is dropped.
REQ-019 SHALL have port histogram, output, 8*(1<<TYPE_W), 8-bit saturating count per type; type t occupies bits [8t+7:8t].

Function
REQ-020 SHALL implement FSM states IDLE, WAIT, WRITE, GAP, SUMMARY and DONE.
REQ-021 An arm pulse in IDLE or DONE SHALL, on the next edge: go to WAIT, clear histogram, log_done, overflow, FIFO, seq and gap counter, and set address to BASE_R_ADDR. arm SHALL be ignored in all other states.
REQ-022 Edge detect SHALL register inference_done. A rising edge while busy SHALL push inferred_type into the FIFO and increment histogram[type], saturating at 255. Edges in IDLE or DONE SHALL be ignored.
REQ-023 If the FIFO is full at a push with no pop in the same cycle, the result SHALL be dropped, overflow SHALL be set and the histogram SHALL still increment.
REQ-024 A push and a pop in the same cycle SHALL both happen, including when the FIFO is full or empty with bypass excluded. A pop from an empty FIFO SHALL never happen.
REQ-025 WAIT with FIFO not empty SHALL go to WRITE.
REQ-026 In WRITE, for one cycle: write=1, writeaddress=address, and writedata = {zero, seq[7:0] in bits [15:8], popped type in bits [TYPE_W-1:0]}. The FIFO SHALL pop, seq SHALL increment, address SHALL advance by W, and the FSM SHALL go to GAP.
REQ-027 GAP SHALL hold write=0 for GAP cycles.
REQ-028 On leaving GAP: if seq==MAX_RESULTS, go to SUMMARY; otherwise go to WAIT.
REQ-029 In SUMMARY, for one cycle: write=1, writeaddress=BASE_R_ADDR+MAX_RESULTS*W, and writedata = {overflow in bit 15, zero, seq[7:0]}. The FSM SHALL then go to DONE.
REQ-030 In DONE: log_done=1. Pushes SHALL be ignored. The FSM SHALL stay until arm.
REQ-031 The address SHALL be ADDR_W bits and wrap modulo 2^ADDR_W.
REQ-032 write SHALL be 0 in every state other than WRITE and SUMMARY.
REQ-033 writeaddress and writedata SHALL be registered and hold their last values when write=0.
REQ-034 Write-to-write spacing SHALL be exactly GAP+1 cycles minimum; latency from FIFO non-empty in WAIT to write SHALL be 1 cycle.

Reset
REQ-035 rst=0 SHALL asynchronously force: state=IDLE, write=0, writeaddress=BASE_R_ADDR, writedata=0, busy=0, log_done=0, overflow=0, histogram=0, FIFO empty, seq=0, edge register=0.
REQ-036 Reset asserted mid-log SHALL abandon the log with no further writes. After rst returns to 1, the block SHALL stay in IDLE until arm.
REQ-037 A held-high inference_done at reset release SHALL count as a rising edge only after it is observed low.

Verification
REQ-038 Scenario: arm, then 10 inference_done pulses spaced 20 cycles with types 1..5,1..5 -> 10 writes at BASE+0..BASE+9W with data 0x0001..0x0905, then summary 0x000A at BASE+10W, log_done=1, histogram[1..5]=2 each.
REQ-039 Scenario: arm, then 6 pulses on consecutive cycles (edges every 2 cycles), DEPTH=4 -> no drop if pops keep up, otherwise overflow=1; summary bit 15 SHALL equal overflow.
REQ-040 Scenario: pulses before arm and after DONE -> no writes, histogram unchanged.
REQ-041 Scenario: rst pulsed low after 3 writes -> outputs at reset values immediately, no write until a new arm; after re-arm the log restarts at BASE.
REQ-042 Scenario: inference_done held high for 50 cycles -> exactly one result logged.
REQ-043 Scenario: 300 pulses of type 0 with MAX_RESULTS=255 -> histogram[0]=255, saturated.
